// File: rtl/transmitter_memory_if.sv
// Host load/start bus and receiver-facing write port of the transmitter buffer.
interface transmitter_memory_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  LoadEnable;
  logic [ADDR_WIDTH-1:0] LoadAddress;
  logic [DATA_WIDTH-1:0] LoadData;
  logic                  Start;
  logic [ADDR_WIDTH-1:0] StartAddress;
  logic [ADDR_WIDTH:0]   WordCount;
  logic [ADDR_WIDTH-1:0] TxAddress;
  logic [DATA_WIDTH-1:0] TxData;
  logic                  TxWriteEnable;
  logic                  Busy;
  logic                  Done;

  modport master (
    output LoadEnable, LoadAddress, LoadData, Start, StartAddress, WordCount,
    input  TxAddress, TxData, TxWriteEnable, Busy, Done
  );

  modport slave (
    input  LoadEnable, LoadAddress, LoadData, Start, StartAddress, WordCount,
    output TxAddress, TxData, TxWriteEnable, Busy, Done
  );
endinterface

// File: rtl/transmitter_memory.sv
// Local 2^ADDR_WIDTH-word buffer that streams a wrap-around block of words to
// the receiver write port, holding each word for two clocks.
module transmitter_memory #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  transmitter_memory_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   count_clamped;
  logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  assign count_clamped = (bus.WordCount > MAX_COUNT) ? MAX_COUNT : bus.WordCount;

  // Host writes only while idle; a same-cycle Start still reads the old word.
  always_ff @(posedge clk) begin
    if (!reset && state_q == IDLE && bus.LoadEnable) begin
      mem_q[bus.LoadAddress] <= bus.LoadData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_addr_q <= '0;
      tx_data_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_addr_q <= tx_addr_d;
      tx_data_q <= tx_data_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.Start) state_d = (count_clamped == '0) ? DONE : SETUP;
      SETUP: state_d = HOLD;
      HOLD:  state_d = (cnt_q > (ADDR_WIDTH+1)'(1)) ? SETUP : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead, so each word is loaded
  // on the edge that enters SETUP.
  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_addr_d = tx_addr_q;
    tx_data_d = tx_data_q;
    we_d      = we_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          cnt_d  = count_clamped;
          idx_d  = bus.StartAddress;
          busy_d = 1'b1;
          if (count_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            tx_addr_d = bus.StartAddress;
            tx_data_d = mem_q[bus.StartAddress];
            we_d      = 1'b1;
          end
        end
      end
      SETUP: ;
      HOLD: begin
        if (cnt_q > (ADDR_WIDTH+1)'(1)) begin
          cnt_d     = cnt_q - (ADDR_WIDTH+1)'(1);
          idx_d     = idx_q + 1'b1;
          tx_addr_d = idx_d;
          tx_data_d = mem_q[idx_d];
        end else begin
          we_d   = 1'b0;
          done_d = 1'b1;
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.TxAddress     = tx_addr_q;
  assign bus.TxData        = tx_data_q;
  assign bus.TxWriteEnable = we_q;
  assign bus.Busy          = busy_q;
  assign bus.Done          = done_q;
endmodule

// File: doc/transmitter_memory.md
# transmitter_memory

Transmit-side buffer and sequencer for the projeto01 link. A host loads up to 16 words into a local 16x16 memory, then pulses `Start`. The block streams a contiguous, wrap-around block of words onto a write port that drives the receiver's `Address`/`DataIn`/`WriteEnable` inputs directly. Each word is held for two clocks, so a receiver that enters its write state one cycle after `WriteEnable` rises captures every word.

## Interface
- `DATA_WIDTH`, 16, word width
- `ADDR_WIDTH`, 4, address width; memory depth is 2^ADDR_WIDTH (16)
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `LoadEnable`  in  1  host write strobe into local memory
- `LoadAddress`  in  ADDR_WIDTH  host write address
- `LoadData`  in  DATA_WIDTH  host write data
- `Start`  in  1  begin transfer; sampled only in IDLE
- `StartAddress`  in  ADDR_WIDTH  first local/remote address of the transfer
- `WordCount`  in  ADDR_WIDTH+1  number of words, 0..16; values above 16 are clamped to 16
- `TxAddress`  out  ADDR_WIDTH  drives the receiver's `Address`
- `TxData`  out  DATA_WIDTH  drives the receiver's `DataIn`
- `TxWriteEnable`  out  1  drives the receiver's `WriteEnable`
- `Busy`  out  1  high in SETUP, HOLD and DONE
- `Done`  out  1  one-cycle pulse at the end of every accepted transfer

## Operation
- States: IDLE, SETUP, HOLD, DONE. All outputs are registered.
- IDLE
  - `Start`=1 with clamped count N>0: latch N, set index = `StartAddress`, go to SETUP.
  - `Start`=1 with N=0: go directly to DONE. No word is sent.
- On entry to SETUP, load `TxAddress` <= index and `TxData` <= mem[index].
- SETUP -> HOLD unconditionally. `TxAddress`, `TxData` and `TxWriteEnable`=1 are unchanged through both cycles.
- HOLD
  - If remaining count > 1: decrement the count, index <= index+1 mod 16, go to SETUP with the next word loaded.
  - Otherwise: go to DONE.
- DONE: `TxWriteEnable`=0, `Done`=1 for exactly one cycle, then IDLE.
- `TxWriteEnable`=1 exactly in SETUP and HOLD. It stays continuously high across consecutive words.
- Address wrap
  - The index wraps modulo 16: `StartAddress`=14, N=4 sends 14, 15, 0, 1.
  - N=16 sends all 16 locations once.
- Local memory
  - `LoadEnable`=1 in IDLE writes mem[`LoadAddress`] <= `LoadData` at the clock edge.
  - `LoadEnable` is ignored while `Busy`=1.
- `Start` while `Busy`=1 is ignored. It is not queued.
- `LoadEnable` and `Start` in the same IDLE cycle: the load is performed. The first word read is the pre-load contents (read-before-write).
- `TxAddress`/`TxData` hold their last values in DONE/IDLE. Only `TxWriteEnable` qualifies them.

## Timing
- Reset values: state IDLE; `TxAddress`=0, `TxData`=0, `TxWriteEnable`=0, `Busy`=0, `Done`=0; internal index and count = 0. Memory contents are not reset.
- Reset asserted mid-transfer:
  - All outputs return to their reset values on the next edge.
  - No `Done` pulse is generated.
  - A word in progress is abandoned.
- Latency: `Start` sampled at edge t means `TxWriteEnable`=1 in the cycle after edge t. Word k (0-based) occupies cycles t+1+2k and t+2+2k.
- Transfer of N words:
  - `Busy` is high for 2N+1 cycles.
  - `Done` is high in cycle t+1+2N.
  - The next `Start` is accepted at the edge ending that cycle+1, i.e. the first IDLE cycle.
- N=0: `Busy` and `Done` are high for one cycle (t+1). `TxWriteEnable` never rises.
- Loaded data is visible to a transfer started on the following cycle or later.

## Test plan
- Reset: assert `reset` 2 cycles with random inputs -> all outputs 0, state IDLE. `Start` during reset is ignored.
- Basic transfer:
  - Stimulus: load mem[i]=16'hA000+i for i=0..15; `Start`, `StartAddress`=0, `WordCount`=3.
  - Response: `TxWriteEnable` high 6 cycles. (`TxAddress`,`TxData`) = (0,A000)x2, (1,A001)x2, (2,A002)x2. `Done` pulses 1 cycle later. A scoreboard receiver_memory holds A000..A002 at addresses 0..2.
- Wrap and clamp:
  - `StartAddress`=14, `WordCount`=4 -> addresses 14, 15, 0, 1.
  - `WordCount`=31 -> exactly 16 words starting at `StartAddress`, 33 `Busy` cycles.
- Zero count: `WordCount`=0 with `Start` -> `Busy`=`Done`=1 for one cycle; `TxWriteEnable` stays 0.
- Interference:
  - `Start` and `LoadEnable` during a transfer -> both ignored; memory unchanged; the transfer completes unaltered.
  - Load to `StartAddress` in the same cycle as `Start` -> the old value is sent.
- Reset mid-transfer: `reset` during the HOLD of word 1 of 4 -> next cycle `TxWriteEnable`=0, `Busy`=0, no `Done`. A following `Start` runs normally.
